param_counter: RTL and testbench
================================

// Module: param_counter
//
// PURPOSE
// Parametrised, mode-programmable counter; next generation of the 6-bit
// free-running wrap counter. Adds runtime limit, up/down direction,
// wrap/saturate/one-shot modes, sync clear/load, and a registered
// terminal-count pulse. Serves as the timebase/sequence counter for
// datapath control; default parameters and inputs reproduce the legacy
// 6-bit behaviour (reset to 63, up-count, wrap to 0).
//
// PARAMETERS
// WIDTH      6                 counter width in bits (>= 1)
// RESET_VAL  {WIDTH{1'b1}}     current_count value on reset (<= 2**WIDTH-1)
//
// PORTS
// clk            in   1      clock, rising edge
// rst            in   1      reset, asynchronous, active-high
// clk_enable     in   1      count-step qualifier; 0 = hold (clear/load still act)
// clear          in   1      sync clear: count <= 0, done <= 0
// load           in   1      sync load: count <= load_value, done <= 0
// load_value     in   WIDTH  value for load
// up_down        in   1      1 = count up, 0 = count down
// mode           in   2      00 wrap, 01 saturate, 10 one-shot, 11 = wrap
// max_count      in   WIDTH  runtime upper limit (inclusive), sampled each cycle
// current_count  out  WIDTH  registered count
// tc_pulse       out  1      registered, 1 cycle per boundary event
// done           out  1      one-shot complete flag (sticky)
//
// BEHAVIOUR
// - Reset (async): current_count = RESET_VAL, tc_pulse = 0, done = 0.
// - Priority per edge: rst > clear > load > enabled step > hold.
// - clear/load: step suppressed; tc_pulse <= 0 that edge.
// - Step occurs only when clk_enable = 1 and done = 0.
// - Boundary: up: count >= max_count; down: count == 0.
// - Non-boundary step: count +/- 1 (no modular arithmetic needed).
// - Boundary step per mode:
//     wrap:      up -> 0; down -> max_count
//     saturate:  up -> max_count (clamps if above); down -> hold 0
//     one-shot:  up -> max_count, done <= 1; down -> hold 0, done <= 1
// - tc_pulse <= 1 on every enabled boundary step; else 0. It is visible
//   in the same cycle as the post-boundary count. Saturate pulses on every
//   enabled cycle at the limit; one-shot pulses once (done blocks steps).
// - done stays 1 until clear, load, or rst; count holds while done = 1.
// - Runtime max_count below count: up-step treated as boundary as above.
//   Down-step decrements normally from any value.
// - max_count = 0, up, wrap: count stays 0, tc_pulse = 1 every enabled cycle.
// - mode/up_down changes take effect on the next edge; no state restart.
// - Load of value > max_count is accepted as-is.
// - All outputs registered; step latency 1 clock.
//
// TESTING
// 1. Defaults, max=63, up, wrap: after rst count=63; 1 enable -> 0,
//    tc_pulse=1 one cycle; 63 more enables -> 63, 64th -> 0 with tc_pulse.
// 2. Down wrap, max=9: load 2; enables -> 1,0,9 (tc_pulse with 9), 8.
// 3. Saturate up, max=5, load 3: enables -> 4,5,5,5; tc_pulse=1 on each
//    enabled cycle at limit; clk_enable=0 -> tc_pulse=0, count holds.
// 4. One-shot up, max=3, clear: enables -> 1,2,3 (done=1, tc once);
//    further enables hold 3; load 0 -> count 0, done=0.
// 5. Priority: clear+load+enable same edge -> 0, tc_pulse=0; load 7 with
//    enable -> 7 (no step); count 50, max lowered to 10, up wrap -> 0 + tc.
// 6. rst asserted between edges mid-count (count=20) -> count=RESET_VAL,
//    tc_pulse=0, done=0 immediately; counting resumes after deassert.

Source files
------------

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_counter
// Brief    : Parametrised up/down counter with runtime limit, wrap/saturate/
//            one-shot modes, sync clear/load and a registered terminal-count
//            pulse. Defaults reproduce the legacy 6-bit wrap counter.
// Revision : 1.0 - initial release
// ============================================================================
module param_counter #(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] current_count,
  output logic             tc_pulse,
  output logic             done
);

  localparam logic [1:0]       c_MODE_SAT  = 2'b01;
  localparam logic [1:0]       c_MODE_ONE  = 2'b10;
  localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ZERO      = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_count_q, w_count_d;
  logic             r_tc_q,    w_tc_d;
  logic             r_done_q,  w_done_d;
  logic             w_step;
  logic             w_at_boundary;

  // A step happens only when enabled and the one-shot has not completed.
  assign w_step = clk_enable && !r_done_q;

  // Up-direction boundary uses >= so a limit lowered below the count still
  // terminates; down-direction boundary is only the zero floor.
  assign w_at_boundary = up_down ? (r_count_q >= max_count) : (r_count_q == c_ZERO);

  // Next-state: clear beats load beats step; clear/load always kill the pulse.
  always_comb begin
    w_count_d = r_count_q;
    w_tc_d    = 1'b0;
    w_done_d  = r_done_q;
    if (clear) begin
      w_count_d = c_ZERO;
      w_done_d  = 1'b0;
    end else if (load) begin
      w_count_d = load_value;
      w_done_d  = 1'b0;
    end else if (w_step) begin
      if (!w_at_boundary) begin
        w_count_d = up_down ? (r_count_q + c_ONE) : (r_count_q - c_ONE);
      end else begin
        w_tc_d = 1'b1;
        if (up_down) begin
          case (mode)
            c_MODE_SAT: w_count_d = max_count;
            c_MODE_ONE: begin
              w_count_d = max_count;
              w_done_d  = 1'b1;
            end
            default:    w_count_d = c_ZERO;
          endcase
        end else begin
          case (mode)
            c_MODE_SAT: w_count_d = c_ZERO;
            c_MODE_ONE: begin
              w_count_d = c_ZERO;
              w_done_d  = 1'b1;
            end
            default:    w_count_d = max_count;
          endcase
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_q <= RESET_VAL;
      r_tc_q    <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_count_q <= w_count_d;
      r_tc_q    <= w_tc_d;
      r_done_q  <= w_done_d;
    end
  end

  assign current_count = r_count_q;
  assign tc_pulse      = r_tc_q;
  assign done          = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_counter
// Brief    : Directed self-checking bench for param_counter (WIDTH = 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_counter;

  logic       clk;
  logic       rst;
  logic       clk_enable;
  logic       clear;
  logic       load;
  logic [5:0] load_value;
  logic       up_down;
  logic [1:0] mode;
  logic [5:0] max_count;
  logic [5:0] current_count;
  logic       tc_pulse;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  param_counter #(.WIDTH(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .clear         (clear),
    .load          (load),
    .load_value    (load_value),
    .up_down       (up_down),
    .mode          (mode),
    .max_count     (max_count),
    .current_count (current_count),
    .tc_pulse      (tc_pulse),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp_count,
                     input logic exp_tc, input logic exp_done);
    n_tests++;
    assert (current_count === exp_count) else begin
      n_fail++;
      $error("FAIL %s count: observed %0d expected %0d", tag, current_count, exp_count);
    end
    n_tests++;
    assert (tc_pulse === exp_tc) else begin
      n_fail++;
      $error("FAIL %s tc_pulse: observed %0b expected %0b", tag, tc_pulse, exp_tc);
    end
    n_tests++;
    assert (done === exp_done) else begin
      n_fail++;
      $error("FAIL %s done: observed %0b expected %0b", tag, done, exp_done);
    end
  endtask

  initial begin
    rst        = 1'b1;
    clk_enable = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = 6'd0;
    up_down    = 1'b1;
    mode       = 2'b00;
    max_count  = 6'd63;

    // 1. Legacy behaviour: reset to 63, up wrap.
    step(); step();
    chk("reset_held", 6'd63, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("reset_release", 6'd63, 1'b0, 1'b0);
    clk_enable = 1'b1;
    step();
    chk("t1_first_wrap", 6'd0, 1'b1, 1'b0);
    repeat (63) step();
    chk("t1_reach_63", 6'd63, 1'b0, 1'b0);
    step();
    chk("t1_second_wrap", 6'd0, 1'b1, 1'b0);
    step();
    chk("t1_after_wrap", 6'd1, 1'b0, 1'b0);

    // 2. Down wrap, max 9, starting from load 2.
    clk_enable = 1'b0; up_down = 1'b0; max_count = 6'd9;
    load = 1'b1; load_value = 6'd2;
    step();
    chk("t2_load2", 6'd2, 1'b0, 1'b0);
    load = 1'b0; clk_enable = 1'b1;
    step(); chk("t2_dn1", 6'd1, 1'b0, 1'b0);
    step(); chk("t2_dn0", 6'd0, 1'b0, 1'b0);
    step(); chk("t2_wrap9", 6'd9, 1'b1, 1'b0);
    step(); chk("t2_dn8", 6'd8, 1'b0, 1'b0);

    // 3. Saturate up, max 5, from load 3.
    clk_enable = 1'b0; up_down = 1'b1; mode = 2'b01; max_count = 6'd5;
    load = 1'b1; load_value = 6'd3;
    step(); chk("t3_load3", 6'd3, 1'b0, 1'b0);
    load = 1'b0; clk_enable = 1'b1;
    step(); chk("t3_up4", 6'd4, 1'b0, 1'b0);
    step(); chk("t3_up5", 6'd5, 1'b0, 1'b0);
    step(); chk("t3_sat_a", 6'd5, 1'b1, 1'b0);
    step(); chk("t3_sat_b", 6'd5, 1'b1, 1'b0);
    clk_enable = 1'b0;
    step(); chk("t3_hold", 6'd5, 1'b0, 1'b0);

    // 4. One-shot up, max 3, from clear.
    mode = 2'b10; max_count = 6'd3; clear = 1'b1;
    step(); chk("t4_clear", 6'd0, 1'b0, 1'b0);
    clear = 1'b0; clk_enable = 1'b1;
    step(); chk("t4_up1", 6'd1, 1'b0, 1'b0);
    step(); chk("t4_up2", 6'd2, 1'b0, 1'b0);
    step(); chk("t4_up3", 6'd3, 1'b0, 1'b0);
    step(); chk("t4_oneshot", 6'd3, 1'b1, 1'b1);
    step(); chk("t4_hold_a", 6'd3, 1'b0, 1'b1);
    step(); chk("t4_hold_b", 6'd3, 1'b0, 1'b1);
    load = 1'b1; load_value = 6'd0;
    step(); chk("t4_load0", 6'd0, 1'b0, 1'b0);
    load = 1'b0;

    // 5. Priority and runtime limit changes (up wrap).
    mode = 2'b00; max_count = 6'd63;
    step(); chk("t5_up1", 6'd1, 1'b0, 1'b0);
    clear = 1'b1; load = 1'b1; load_value = 6'd5;
    step(); chk("t5_clear_wins", 6'd0, 1'b0, 1'b0);
    clear = 1'b0; load_value = 6'd7;
    step(); chk("t5_load_no_step", 6'd7, 1'b0, 1'b0);
    max_count = 6'd10; load_value = 6'd50;
    step(); chk("t5_load_above_max", 6'd50, 1'b0, 1'b0);
    load = 1'b0;
    step(); chk("t5_lowered_max", 6'd0, 1'b1, 1'b0);
    max_count = 6'd0;
    step(); chk("t5_max0_a", 6'd0, 1'b1, 1'b0);
    step(); chk("t5_max0_b", 6'd0, 1'b1, 1'b0);
    // Down-step from above the limit decrements normally.
    max_count = 6'd10; mode = 2'b01; up_down = 1'b0;
    load = 1'b1; load_value = 6'd50;
    step(); chk("t5_load50", 6'd50, 1'b0, 1'b0);
    load = 1'b0;
    step(); chk("t5_dn_above_max", 6'd49, 1'b0, 1'b0);

    // 6. Asynchronous reset mid-cycle while done and tc_pulse are set.
    up_down = 1'b1; mode = 2'b10; max_count = 6'd20;
    load = 1'b1; load_value = 6'd20;
    step(); chk("t6_load20", 6'd20, 1'b0, 1'b0);
    load = 1'b0;
    step(); chk("t6_done", 6'd20, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", 6'd63, 1'b0, 1'b0);
    #2 rst = 1'b0;
    mode = 2'b00; max_count = 6'd63;
    step(); chk("t6_resume_wrap", 6'd0, 1'b1, 1'b0);
    step(); chk("t6_resume_up", 6'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
